// File: rtl/alu_pkg.sv
// Shared ALU opcode and requester-ID constants for the ALU and the
// two-requester arbiter that fronts it.
package alu_pkg;

  typedef logic [3:0] aluctr_t;

  localparam aluctr_t ALU_ADD = 4'b0000;
  localparam aluctr_t ALU_SUB = 4'b0001;
  localparam aluctr_t ALU_AND = 4'b0010;
  localparam aluctr_t ALU_OR  = 4'b0011;
  localparam aluctr_t ALU_XOR = 4'b0100;
  localparam aluctr_t ALU_SLT = 4'b0101;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle of the shared-ALU arbiter: two valid/ready
// requesters in, one valid/ready response out.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  import alu_pkg::*;

  logic                  i_req0_valid;
  logic                  o_req0_ready;
  logic [DATA_WIDTH-1:0] i_req0_a;
  logic [DATA_WIDTH-1:0] i_req0_b;
  aluctr_t               i_req0_aluctr;

  logic                  i_req1_valid;
  logic                  o_req1_ready;
  logic [DATA_WIDTH-1:0] i_req1_a;
  logic [DATA_WIDTH-1:0] i_req1_b;
  aluctr_t               i_req1_aluctr;

  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic                  o_rsp_id;
  logic [DATA_WIDTH-1:0] o_rsp_result;
  logic                  o_rsp_cf;
  logic                  o_rsp_zf;
  logic                  o_rsp_of;
  logic                  o_rsp_sf;

  // Requesters and the response consumer.
  modport master (
    output i_req0_valid, i_req0_a, i_req0_b, i_req0_aluctr,
    output i_req1_valid, i_req1_a, i_req1_b, i_req1_aluctr,
    output i_rsp_ready,
    input  o_req0_ready, o_req1_ready,
    input  o_rsp_valid, o_rsp_id, o_rsp_result,
    input  o_rsp_cf, o_rsp_zf, o_rsp_of, o_rsp_sf
  );

  // The arbiter itself.
  modport slave (
    input  i_req0_valid, i_req0_a, i_req0_b, i_req0_aluctr,
    input  i_req1_valid, i_req1_a, i_req1_b, i_req1_aluctr,
    input  i_rsp_ready,
    output o_req0_ready, o_req1_ready,
    output o_rsp_valid, o_rsp_id, o_rsp_result,
    output o_rsp_cf, o_rsp_zf, o_rsp_of, o_rsp_sf
  );

endinterface

// File: rtl/alu.sv
// Combinational ALU: add/sub/and/or/xor/signed-less-than with carry,
// zero, overflow and sign flags. Unknown opcodes yield a zero result.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  aluctr_t               aluctr,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  cf,
  output logic                  zf,
  output logic                  of,
  output logic                  sf
);

  localparam int MSB = DATA_WIDTH - 1;

  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] diff;
  logic                lt;

  // NOTE: every output of a combinational block gets a default before the
  // case, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    result = '0;
    cf     = 1'b0;
    of     = 1'b0;
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    lt     = $signed(a) < $signed(b);

    case (aluctr)
      ALU_ADD: begin
        result = sum[MSB:0];
        cf     = sum[DATA_WIDTH];
        of     = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        // Carry on subtract reports an unsigned borrow.
        result = diff[MSB:0];
        cf     = diff[DATA_WIDTH];
        of     = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(DATA_WIDTH-1){1'b0}}, lt};
      default: result = '0;
    endcase

    zf = (result == '0);
    sf = result[MSB];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; the result is
// held in a one-entry response buffer tagged with the winning requester.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  alu_arbiter_if.slave   bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

  buf_state_t state_q, state_d;
  logic       last_grant_q;
  logic       grant;
  logic       can_accept;
  logic       ready0, ready1;
  logic       accept;

  logic [DATA_WIDTH-1:0] alu_a, alu_b, alu_result;
  aluctr_t               alu_ctr;
  logic                  alu_cf, alu_zf, alu_of, alu_sf;

  logic [DATA_WIDTH-1:0] rsp_result_q;
  logic                  rsp_id_q;
  logic                  rsp_cf_q, rsp_zf_q, rsp_of_q, rsp_sf_q;

  // Under contention the requester that did not win last time goes next.
  always_comb begin
    grant = REQ0;
    if (bus.i_req0_valid && bus.i_req1_valid)
      grant = (last_grant_q == REQ0) ? REQ1 : REQ0;
    else if (bus.i_req1_valid)
      grant = REQ1;
  end

  assign can_accept = (state_q == EMPTY) || bus.i_rsp_ready;
  assign ready0     = can_accept && bus.i_req0_valid && (grant == REQ0);
  assign ready1     = can_accept && bus.i_req1_valid && (grant == REQ1);
  assign accept     = ready0 || ready1;

  assign bus.o_req0_ready = ready0;
  assign bus.o_req1_ready = ready1;

  // Requester 0 feeds the ALU whenever requester 1 is not being accepted.
  always_comb begin
    alu_a   = bus.i_req0_a;
    alu_b   = bus.i_req0_b;
    alu_ctr = bus.i_req0_aluctr;
    if (ready1) begin
      alu_a   = bus.i_req1_a;
      alu_b   = bus.i_req1_b;
      alu_ctr = bus.i_req1_aluctr;
    end
  end

  alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .aluctr (alu_ctr),
    .result (alu_result),
    .cf     (alu_cf),
    .zf     (alu_zf),
    .of     (alu_of),
    .sf     (alu_sf)
  );

  always_comb begin
    state_d = state_q;
    if (accept)
      state_d = FULL;
    else if (state_q == FULL && bus.i_rsp_ready)
      state_d = EMPTY;
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or process order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= EMPTY;
      last_grant_q <= REQ1;
    end else begin
      state_q <= state_d;
      if (accept)
        last_grant_q <= grant;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_result_q <= '0;
      rsp_id_q     <= REQ0;
      rsp_cf_q     <= 1'b0;
      rsp_zf_q     <= 1'b0;
      rsp_of_q     <= 1'b0;
      rsp_sf_q     <= 1'b0;
    end else if (accept) begin
      rsp_result_q <= alu_result;
      rsp_id_q     <= grant;
      rsp_cf_q     <= alu_cf;
      rsp_zf_q     <= alu_zf;
      rsp_of_q     <= alu_of;
      rsp_sf_q     <= alu_sf;
    end
  end

  assign bus.o_rsp_valid  = (state_q == FULL);
  assign bus.o_rsp_id     = rsp_id_q;
  assign bus.o_rsp_result = rsp_result_q;
  assign bus.o_rsp_cf     = rsp_cf_q;
  assign bus.o_rsp_zf     = rsp_zf_q;
  assign bus.o_rsp_of     = rsp_of_q;
  assign bus.o_rsp_sf     = rsp_sf_q;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one combinational `alu` instance between two requesters, for example the integer pipe and a debug/CSR path, using valid/ready handshakes. Each cycle a round-robin arbiter picks one request and drives its operands and opcode into the ALU. The result and flags are captured in a one-entry registered response buffer, tagged with the winning requester ID. The response is then presented to a single consumer with its own valid/ready handshake.

Parameters:
DATA_WIDTH, 32, operand/result width; passed to the `alu` instance.

Ports:
i_clk  input  1  clock; all state on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_req0_valid  input  1  requester 0 has an operation
o_req0_ready  output  1  requester 0 accepted this cycle when valid&&ready
i_req0_a  input  DATA_WIDTH  requester 0 operand A
i_req0_b  input  DATA_WIDTH  requester 0 operand B
i_req0_aluctr  input  4  requester 0 ALU opcode
i_req1_valid  input  1  requester 1 has an operation
o_req1_ready  output  1  requester 1 accepted this cycle when valid&&ready
i_req1_a  input  DATA_WIDTH  requester 1 operand A
i_req1_b  input  DATA_WIDTH  requester 1 operand B
i_req1_aluctr  input  4  requester 1 ALU opcode
o_rsp_valid  output  1  response buffer holds a result
i_rsp_ready  input  1  consumer takes response when valid&&ready
o_rsp_id  output  1  requester that issued the response
o_rsp_result  output  DATA_WIDTH  registered ALU result
o_rsp_cf / o_rsp_zf / o_rsp_of / o_rsp_sf  output  1 each  registered ALU flags

Behaviour:
- Reset (i_rst_n low, asynchronous): buffer goes to EMPTY. o_rsp_valid=0, o_rsp_id=0, o_rsp_result=0, all flags=0. Round-robin pointer last_grant=1, so requester 0 wins the first contention.
- Buffer FSM:
  - EMPTY → FULL on accept.
  - FULL → FULL on drain+accept in the same cycle.
  - FULL → EMPTY on drain without accept.
  - FULL stays FULL while stalled (o_rsp_valid && !i_rsp_ready).
  - o_rsp_valid = (state==FULL).
- can_accept = EMPTY || (FULL && i_rsp_ready). Full throughput is one op per cycle.
- Grant is combinational from the current valids and last_grant:
  - only one valid → that requester;
  - both valid → the requester != last_grant.
- o_reqN_ready = can_accept && grant==N. At most one ready is high per cycle. Ready is never high for a requester whose valid is low.
- Accept = valid && ready on the granted requester. On accept:
  - the ALU is driven from the granted requester's a/b/aluctr;
  - result, flags and ID are registered at the next edge (latency 1 cycle, accept edge to o_rsp_valid);
  - last_grant updates only on accept.
- No accept → ALU inputs are driven from requester 0 (don't-care). No register or pointer update.
- Stall: all o_rsp_* outputs are held bit-stable while o_rsp_valid && !i_rsp_ready. Both o_reqN_ready are 0.
- Requesters hold a/b/aluctr stable while valid && !ready. A requester may drop valid before acceptance; the arbiter tolerates this with no state change.
- Opcodes outside 0000–0101 are forwarded unchanged; result and flags are whatever `alu` produces. No error path.
- Flags are registered exactly as `alu` outputs them. No reinterpretation per opcode.
- Reset asserted mid-operation: a buffered or stalled response is discarded immediately, without waiting for a clock edge. The first post-reset grant goes to requester 0.

Decomposition:
- Shared package `alu_pkg`: the ALU opcode constants (ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101) and the requester-ID constants (REQ0=0, REQ1=1).
- Buffer state encoding (EMPTY/FULL) stays local.
- Sub-module: the existing `alu`, instantiated once with DATA_WIDTH passed through.
- Arbitration and the response register stay in alu_arbiter; no further split.

Test Plan:
1. Reset → hold i_rst_n=0 with random inputs, then release → all o_rsp_* = 0, o_req0_ready=1 if req0 valid.
2. Single request → req0 ADD a=0x10 b=0x20 for one cycle, i_rsp_ready=1 → next cycle o_rsp_valid=1, id=0, result=0x00000030, zf=0, cf=0.
3. Contention → in the same cycle req0 SUB 0x30-0x10 and req1 AND 0x0F&0xF0:
   - first response: id=0, result=0x20;
   - second response (next cycle): id=1, result=0x0, zf=1.
4. Fairness → both requesters continuously valid for 6 accepts, i_rsp_ready=1 → ids 0,1,0,1,0,1, one response per cycle, no bubbles.
5. Back-pressure → req1 XOR 0x0F^0xF0 accepted, i_rsp_ready=0 for 3 cycles:
   - o_rsp_result=0xFF held stable, both readys=0;
   - then i_rsp_ready=1 with req0 SLT 0x10,0x20 pending → same-edge drain+accept, next response id=0, result=0x1.
6. Reset mid-operation → stalled FULL buffer, pull i_rst_n low between edges → o_rsp_valid falls immediately; after release with both valid, first grant is req0.
